// File: rtl/clock_pkg.sv
// Shared types and constants for the 12-hour BCD clock controller.
package clock_pkg;

    // Display/state code. The encoding values are visible on the mode output.
    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StSetHr  = 3'd1,
        StSetMin = 3'd2,
        StAlmHr  = 3'd3,
        StAlmMin = 3'd4
    } state_e;

    // One BCD 12-hour time value: HH:MM plus AM/PM (ap=1 means PM).
    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h2;
        logic [3:0] m1;
        logic [3:0] m2;
        logic       ap;
    } bcd_time_t;

    localparam bcd_time_t ResetTime = '{h1: 4'd1, h2: 4'd2, m1: 4'd0, m2: 4'd0, ap: 1'b0};

    localparam logic [3:0] BcdDigitMax   = 4'd9;
    localparam logic [3:0] BcdMinTensMax = 4'd5;
    localparam logic [7:0] HourMax       = 8'd12;

    // Binary value of a two-digit BCD hour; out-of-range digits give values above 12.
    function automatic logic [7:0] hour_bin(input logic [3:0] tens, input logic [3:0] units);
        return (8'(tens) * 8'd10) + 8'(units);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel / counter side signals of the clock set controller.
interface clock_set_ctrl_if;

    logic       btn_mode;
    logic       btn_inc;
    logic       alarm_en;
    logic [3:0] h1;
    logic [3:0] h2;
    logic [3:0] m1;
    logic [3:0] m2;
    logic       ap;

    logic       min_tick;
    logic       load;
    logic [3:0] ld_h1;
    logic [3:0] ld_h2;
    logic [3:0] ld_m1;
    logic [3:0] ld_m2;
    logic       ld_ap;
    logic [2:0] mode;
    logic       ring;

    // Controller side.
    modport master (
        input  btn_mode, btn_inc, alarm_en, h1, h2, m1, m2, ap,
        output min_tick, load, ld_h1, ld_h2, ld_m1, ld_m2, ld_ap, mode, ring
    );

    // Panel/counter side.
    modport slave (
        output btn_mode, btn_inc, alarm_en, h1, h2, m1, m2, ap,
        input  min_tick, load, ld_h1, ld_h2, ld_m1, ld_m2, ld_ap, mode, ring
    );

endinterface

// File: rtl/bcd_time_inc.sv
// Combinational single-step increment of either the hour or the minute field of a BCD time.
module bcd_time_inc
    import clock_pkg::*;
(
    input  bcd_time_t cur_i,
    input  logic      sel_hr_i,
    output bcd_time_t nxt_o
);

    logic [7:0] hour;
    logic [7:0] hour_nxt;

    // Hours cycle 01..12 (11->12 flips AM/PM); minutes cycle 00..59 without hour carry.
    always_comb begin
        nxt_o    = cur_i;
        hour     = hour_bin(cur_i.h1, cur_i.h2);
        hour_nxt = hour + 8'd1;
        if (sel_hr_i) begin
            if (hour == HourMax - 8'd1) begin
                nxt_o.h1 = 4'd1;
                nxt_o.h2 = 4'd2;
                nxt_o.ap = ~cur_i.ap;
            end else if ((hour < HourMax - 8'd1) && (cur_i.h2 <= BcdDigitMax)) begin
                if (hour_nxt >= 8'd10) begin
                    nxt_o.h1 = 4'd1;
                    nxt_o.h2 = 4'(hour_nxt - 8'd10);
                end else begin
                    nxt_o.h1 = 4'd0;
                    nxt_o.h2 = hour_nxt[3:0];
                end
            end else begin
                // 12 and any non-canonical hour restart at 01 with AM/PM kept.
                nxt_o.h1 = 4'd0;
                nxt_o.h2 = 4'd1;
            end
        end else begin
            if (cur_i.m2 < BcdDigitMax) begin
                nxt_o.m2 = cur_i.m2 + 4'd1;
            end else begin
                nxt_o.m2 = 4'd0;
                if (cur_i.m1 < BcdMinTensMax) begin
                    nxt_o.m1 = cur_i.m1 + 4'd1;
                end else begin
                    nxt_o.m1 = 4'd0;
                end
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Sequencer for the BCD 12-hour counter: minute prescaler, set/alarm edit FSM, alarm ring.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 6000,
    parameter int unsigned CNT_W    = 13
) (
    input logic             clk,
    input logic             reset,
    clock_set_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] PrescMax = CNT_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             min_tick_q, min_tick_d;
    logic             load_q, load_d;
    logic             ring_q, ring_d;
    logic             match_q;
    bcd_time_t        edit_q, edit_d;
    bcd_time_t        alarm_q, alarm_d;
    bcd_time_t        live, edit_inc, alarm_inc;
    logic             match;
    logic             mode_go;
    logic             inc_go;

    assign live  = '{h1: bus.h1, h2: bus.h2, m1: bus.m1, m2: bus.m2, ap: bus.ap};
    assign match = (live == alarm_q);

    // A ringing alarm swallows the first button press; mode beats inc when both arrive together.
    assign mode_go = bus.btn_mode && !ring_q;
    assign inc_go  = bus.btn_inc && !bus.btn_mode && !ring_q;

    bcd_time_inc u_time_inc (
        .cur_i    (edit_q),
        .sel_hr_i (state_q == StSetHr),
        .nxt_o    (edit_inc)
    );

    bcd_time_inc u_alarm_inc (
        .cur_i    (alarm_q),
        .sel_hr_i (state_q == StAlmHr),
        .nxt_o    (alarm_inc)
    );

    // Edit FSM next state; leaving SET_MIN commits the edited time to the counter.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        if (mode_go) begin
            unique case (state_q)
                StRun:    state_d = StSetHr;
                StSetHr:  state_d = StSetMin;
                StSetMin: begin
                    state_d = StAlmHr;
                    load_d  = 1'b1;
                end
                StAlmHr:  state_d = StAlmMin;
                StAlmMin: state_d = StRun;
                default:  state_d = StRun;
            endcase
        end
    end

    // Edit and alarm registers: snapshot live time on entering edit, then step on btn_inc.
    always_comb begin
        edit_d  = edit_q;
        alarm_d = alarm_q;
        if ((state_q == StRun) && mode_go) begin
            edit_d = live;
        end else if (inc_go) begin
            if ((state_q == StSetHr) || (state_q == StSetMin)) begin
                edit_d = edit_inc;
            end else if ((state_q == StAlmHr) || (state_q == StAlmMin)) begin
                alarm_d = alarm_inc;
            end
        end
    end

    // Prescaler only runs in RUN so the displayed time freezes while editing.
    always_comb begin
        presc_d    = '0;
        min_tick_d = 1'b0;
        if ((state_q == StRun) && !mode_go) begin
            min_tick_d = (presc_q == PrescMax);
            presc_d    = (presc_q == PrescMax) ? '0 : presc_q + CNT_W'(1);
        end
    end

    // Ring latches on a rising match in RUN and drops on any button, disable or match loss.
    always_comb begin
        ring_d = 1'b0;
        if ((state_q == StRun) && (state_d == StRun)) begin
            if (ring_q) begin
                ring_d = !(bus.btn_mode || bus.btn_inc || !bus.alarm_en || !match);
            end else begin
                ring_d = bus.alarm_en && match && !match_q;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            presc_q    <= '0;
            min_tick_q <= 1'b0;
            load_q     <= 1'b0;
            ring_q     <= 1'b0;
            match_q    <= 1'b0;
            edit_q     <= ResetTime;
            alarm_q    <= ResetTime;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            min_tick_q <= min_tick_d;
            load_q     <= load_d;
            ring_q     <= ring_d;
            match_q    <= match;
            edit_q     <= edit_d;
            alarm_q    <= alarm_d;
        end
    end

    assign bus.min_tick = min_tick_q;
    assign bus.load     = load_q;
    assign bus.ld_h1    = edit_q.h1;
    assign bus.ld_h2    = edit_q.h2;
    assign bus.ld_m1    = edit_q.m1;
    assign bus.ld_m2    = edit_q.m2;
    assign bus.ld_ap    = edit_q.ap;
    assign bus.mode     = state_q;
    assign bus.ring     = ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a 4-cycle minute prescaler.
module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tm(input logic [3:0] h1, input logic [3:0] h2,
                                       input logic [3:0] m1, input logic [3:0] m2,
                                       input logic ap);
        return {15'd0, h1, h2, m1, m2, ap};
    endfunction

    function automatic logic [31:0] ld_now();
        return {15'd0, bus.ld_h1, bus.ld_h2, bus.ld_m1, bus.ld_m2, bus.ld_ap};
    endfunction

    task automatic set_live(input logic [3:0] h1, input logic [3:0] h2, input logic [3:0] m1,
                            input logic [3:0] m2, input logic ap);
        bus.h1 = h1;
        bus.h2 = h2;
        bus.m1 = m1;
        bus.m2 = m2;
        bus.ap = ap;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
    endtask

    task automatic pulse_inc();
        bus.btn_inc = 1'b1;
        tick();
        bus.btn_inc = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.alarm_en = 1'b0;
        set_live(4'd1, 4'd1, 4'd5, 4'd9, 1'b0);
        #12;
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_load", 32'(bus.load), 32'd0);
        check("rst_tick", 32'(bus.min_tick), 32'd0);
        check("rst_ring", 32'(bus.ring), 32'd0);
        check("rst_ld", ld_now(), tm(4'd1, 4'd2, 4'd0, 4'd0, 1'b0));

        // Free run: tick after the 4th, 8th and 12th edge following release.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("run_tick_%0d", k), 32'(bus.min_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
            check($sformatf("run_load_%0d", k), 32'(bus.load), 32'd0);
            check($sformatf("run_mode_%0d", k), 32'(bus.mode), 32'd0);
        end

        // Set time from live 11:59 AM.
        pulse_mode();
        check("set_mode1", 32'(bus.mode), 32'd1);
        check("capture", ld_now(), tm(4'd1, 4'd1, 4'd5, 4'd9, 1'b0));
        pulse_inc();
        check("hr_11_12", ld_now(), tm(4'd1, 4'd2, 4'd5, 4'd9, 1'b1));
        pulse_inc();
        check("hr_12_01", ld_now(), tm(4'd0, 4'd1, 4'd5, 4'd9, 1'b1));
        pulse_mode();
        check("set_mode2", 32'(bus.mode), 32'd2);
        pulse_inc();
        check("min_wrap", ld_now(), tm(4'd0, 4'd1, 4'd0, 4'd0, 1'b1));
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("frozen_tick_%0d", k), 32'(bus.min_tick), 32'd0);
        end
        check("no_load_edit", 32'(bus.load), 32'd0);
        pulse_mode();
        check("load_hi", 32'(bus.load), 32'd1);
        check("load_mode3", 32'(bus.mode), 32'd3);
        check("load_val", ld_now(), tm(4'd0, 4'd1, 4'd0, 4'd0, 1'b1));
        tick();
        check("load_lo", 32'(bus.load), 32'd0);

        // Alarm edit: 12:00 AM -> 01:00 AM.
        pulse_inc();
        check("alm_not_time", ld_now(), tm(4'd0, 4'd1, 4'd0, 4'd0, 1'b1));
        pulse_mode();
        check("alm_mode4", 32'(bus.mode), 32'd4);
        pulse_mode();
        check("back_run", 32'(bus.mode), 32'd0);
        check("back_noload", 32'(bus.load), 32'd0);
        bus.alarm_en = 1'b1;
        tick();
        check("no_ring_yet", 32'(bus.ring), 32'd0);
        set_live(4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
        tick();
        check("ring_set", 32'(bus.ring), 32'd1);
        tick();
        check("ring_hold", 32'(bus.ring), 32'd1);
        pulse_inc();
        check("ring_clr_inc", 32'(bus.ring), 32'd0);
        check("ring_clr_mode0", 32'(bus.mode), 32'd0);
        tick();
        check("ring_no_reset", 32'(bus.ring), 32'd0);

        // Mode press while ringing only clears the ring.
        set_live(4'd0, 4'd1, 4'd0, 4'd1, 1'b0);
        tick();
        set_live(4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
        tick();
        check("ring_set2", 32'(bus.ring), 32'd1);
        pulse_mode();
        check("ring_clr_btn", 32'(bus.ring), 32'd0);
        check("ring_mode_kept", 32'(bus.mode), 32'd0);

        // Disable clears the ring.
        set_live(4'd0, 4'd1, 4'd0, 4'd1, 1'b0);
        tick();
        set_live(4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
        tick();
        check("ring_set3", 32'(bus.ring), 32'd1);
        bus.alarm_en = 1'b0;
        tick();
        check("ring_clr_en", 32'(bus.ring), 32'd0);

        // Minute carry and simultaneous buttons in SET_MIN.
        pulse_mode();
        pulse_mode();
        check("sim_mode2", 32'(bus.mode), 32'd2);
        for (int k = 0; k < 10; k++) pulse_inc();
        check("min_carry", ld_now(), tm(4'd0, 4'd1, 4'd1, 4'd0, 1'b0));
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        check("sim_mode3", 32'(bus.mode), 32'd3);
        check("sim_noinc", ld_now(), tm(4'd0, 4'd1, 4'd1, 4'd0, 1'b0));
        check("sim_load", 32'(bus.load), 32'd1);
        tick();
        check("sim_load_once", 32'(bus.load), 32'd0);
        pulse_mode();
        pulse_mode();
        check("sim_run", 32'(bus.mode), 32'd0);

        // Hour 09 -> 10, then asynchronous reset in the middle of a minute edit.
        set_live(4'd0, 4'd9, 4'd3, 4'd0, 1'b1);
        pulse_mode();
        pulse_inc();
        check("hr_09_10", ld_now(), tm(4'd1, 4'd0, 4'd3, 4'd0, 1'b1));
        pulse_mode();
        pulse_inc();
        check("pre_reset", ld_now(), tm(4'd1, 4'd0, 4'd3, 4'd1, 1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("arst_mode", 32'(bus.mode), 32'd0);
        check("arst_ring", 32'(bus.ring), 32'd0);
        check("arst_load", 32'(bus.load), 32'd0);
        check("arst_ld", ld_now(), tm(4'd1, 4'd2, 4'd0, 4'd0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post_rst_load_%0d", k), 32'(bus.load), 32'd0);
        end

        // Invalid hour captured verbatim, increments to 01.
        set_live(4'd1, 4'd3, 4'd0, 4'd0, 1'b0);
        pulse_mode();
        check("cap_13", ld_now(), tm(4'd1, 4'd3, 4'd0, 4'd0, 1'b0));
        pulse_inc();
        check("hr_13_01", ld_now(), tm(4'd0, 4'd1, 4'd0, 4'd0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Controller that sequences the BCD 12-hour time counter (h1,h2,m1,m2,ap).
- Generates the minute-tick enable that advances the counter.
- Runs a button-driven set-mode FSM for editing time and alarm, then issues a one-cycle load of the edited time into the counter.
- Compares the live time against a stored alarm and drives a ring output.
- Sits between the debounced front-panel buttons and the clock counter.

Parameters:
- TICK_DIV, 6000, clk cycles per minute tick; must be >= 2.
- CNT_W, 13, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- btn_mode  in  1  single-cycle pulse, already debounced; advances the FSM
- btn_inc  in  1  single-cycle pulse, already debounced; increments the edited field
- alarm_en  in  1  level; enables the alarm
- h1,h2,m1,m2  in  4 each  live BCD time from the counter
- ap  in  1  live AM/PM (0=AM, 1=PM)
- min_tick  out  1  one-cycle counter advance pulse
- load  out  1  one-cycle strobe; the counter takes ld_* on this cycle
- ld_h1,ld_h2,ld_m1,ld_m2  out  4 each  time value to load
- ld_ap  out  1  AM/PM value to load
- mode  out  3  one-hot-free state code for display: RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4
- ring  out  1  alarm active

Behaviour:
- Reset (async, any state, mid-edit included):
  - state=RUN; prescaler=0; min_tick=0; load=0; ring=0.
  - Edit registers (ld_*) = 12:00 AM, i.e. 1,2,0,0,ap=0.
  - Alarm registers = 12:00 AM.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - min_tick=1 on the cycle the prescaler holds TICK_DIV-1, so the first tick comes TICK_DIV cycles after reset release.
- Non-RUN states: prescaler held at 0 and min_tick=0, so time freezes while editing.
- FSM advances on btn_mode: RUN -> SET_HR -> SET_MIN -> ALM_HR -> ALM_MIN -> RUN.
  - RUN->SET_HR: the edit registers capture the live h1,h2,m1,m2,ap in the same cycle.
  - SET_MIN->ALM_HR: load=1 for exactly one cycle, with ld_* holding the edited value. The prescaler restarts from 0 on the return to RUN.
  - ALM_MIN->RUN: no load; the alarm registers hold their edited values.
- btn_inc, hour states (SET_HR edits the time registers, ALM_HR edits the alarm registers):
  - Hours step 01..12.
  - 11->12 toggles ap.
  - 12->01 leaves ap unchanged.
  - 09->10 sets h1=1, h2=0.
- btn_inc, minute states (SET_MIN edits time, ALM_MIN edits alarm):
  - Minutes step 00..59.
  - 59->00 wraps with no hour carry.
  - m2 9->0 increments m1.
- btn_inc in RUN: ignored.
- btn_mode and btn_inc in the same cycle: the mode transition wins; inc is dropped.
- Outputs are registered; each state change is visible on the cycle after the button pulse.
- Alarm compare: match = (h1,h2,m1,m2,ap inputs == alarm registers).
  - ring sets on the rising edge of match, only in RUN with alarm_en=1.
  - ring clears on any of: btn_mode, btn_inc, alarm_en=0, match falling.
  - Button priority while ring=1: the first button press only clears ring and does not change state or increment.
  - ring is held at 0 in all non-RUN states.
- Invalid BCD on the inputs: captured verbatim. Increment from a non-canonical hour (e.g. 13) yields 01.

Decomposition:
- Shared package clock_pkg holds:
  - state encoding constants (RUN..ALM_MIN);
  - the reset time constant 12:00 AM;
  - BCD limit constants 9, 5, 12.
- One natural sub-module, bcd_time_inc. It is combinational, instantiated twice (time edit, alarm edit).
  - Inputs: h1,h2,m1,m2,ap, sel_hr.
  - Outputs: the incremented fields, per the hour/minute rules above.

Test Plan:
- Free run, TICK_DIV=4: release reset, no buttons -> min_tick high on cycles 4, 8, 12 after release; load=0; mode=0.
- Set time, live input 11:59 AM:
  - Step 1: btn_mode, then btn_inc -> ld shows 12:59 PM (ap=1).
  - Step 2: btn_inc again -> 01:59, ap=1.
  - Step 3: btn_mode, then btn_inc -> 01:00.
  - Step 4: btn_mode -> load=1 for one cycle with 0,1,0,0,ap=1; mode=3.
- Alarm edit then match:
  - Set alarm to 01:00 AM via the ALM states, return to RUN, alarm_en=1.
  - Drive the input time 01:00 AM -> ring=1 the next cycle.
  - btn_inc -> ring=0 and mode stays 0.
- Simultaneous buttons: in SET_MIN, pulse btn_mode and btn_inc together -> mode=3, minutes unchanged, load pulse once.
- Reset mid-edit: in SET_MIN with edits pending, assert reset asynchronously (between edges) -> mode=0, ring=0, load=0, ld_* = 1,2,0,0,0 immediately; no load pulse after release.
- Minute wrap: in SET_MIN at 59, btn_inc -> m1=0, m2=0, hours unchanged.
